// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller.
// The optional statistics counters are enabled with the CACHE_STATS_EN macro.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    WRITE  = 2'd3
  } cache_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_SETS   = 64;
  localparam int IDX_W      = clog2(DEF_SETS);
  localparam int TAG_W      = DEF_ADDR_W - IDX_W;

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age storage: touch update and victim selection.
// Age 0 is the most recently used way; the oldest way has the largest age.
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  localparam int IW = clog2(SETS),
  localparam int WW = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   idx,
  input  logic [WAYS-1:0] valid,
  input  logic            touch,
  input  logic [WW-1:0]   touch_way,
  output logic [WW-1:0]   victim
);

  generate
    if (WAYS == 1) begin : g_dm
      assign victim = '0;
    end else begin : g_lru
      logic [WW-1:0] age [SETS][WAYS];
      logic          found;
      logic [WW-1:0] best_age;

      // Ages all start equal after reset, so equal-aged ways count as younger;
      // this turns the ages into a permutation as the set fills up.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age[s][w] <= '0;
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (w == int'(touch_way))
              age[idx][w] <= '0;
            else if ((age[idx][w] <= age[idx][touch_way]) && (age[idx][w] != '1))
              age[idx][w] <= age[idx][w] + 1'b1;
          end
        end
      end

      always_comb begin
        victim   = '0;
        found    = 1'b0;
        best_age = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (!valid[w]) begin
            victim = WW'(w);
            found  = 1'b1;
          end
        end
        if (!found) begin
          for (int w = 0; w < WAYS; w++) begin
            if (age[idx][w] > best_age) begin
              best_age = age[idx][w];
              victim   = WW'(w);
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cache_ctrl_sa.sv
// Set-associative write-through / no-write-allocate cache controller with true LRU.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_ctrl_sa
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              hit,
  output logic [DATA_W-1:0] outData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef CACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output cache_state_e      dbg_state
);

  localparam int IW = clog2(SETS);
  localparam int TW = ADDR_W - IW;
  localparam int WW = (WAYS > 1) ? clog2(WAYS) : 1;

  cache_state_e      state, next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [IW-1:0]     lat_idx;
  logic [TW-1:0]     lat_tag;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TW-1:0]     tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  logic              lk_hit;
  logic [WW-1:0]     lk_way;
  logic [WW-1:0]     victim;
  logic              fill_done, write_done;
  logic              lru_touch;
  logic [WW-1:0]     lru_way;

  assign lat_idx    = lat_addr[IW-1:0];
  assign lat_tag    = lat_addr[ADDR_W-1:IW];
  assign fill_done  = (state == FILL)  && mem_req && mem_ack;
  assign write_done = (state == WRITE) && mem_req && mem_ack;
  assign lru_touch  = ((state == LOOKUP) && lk_hit) || fill_done;
  assign lru_way    = fill_done ? victim : lk_way;
  assign dbg_state  = state;

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lat_idx][w] && (tag_q[lat_idx][w] == lat_tag)) begin
        lk_hit = 1'b1;
        lk_way = WW'(w);
      end
    end
  end

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .idx       (lat_idx),
    .valid     (valid_q[lat_idx]),
    .touch     (lru_touch),
    .touch_way (lru_way),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = LOOKUP;
      LOOKUP:  next_state = lat_we ? WRITE : (lk_hit ? IDLE : FILL);
      FILL:    if (fill_done) next_state = IDLE;
      WRITE:   if (write_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, request latch and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ready <= 1'b0;
      hit       <= 1'b0;
      outData   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_addr  <= address;
            lat_we    <= cpu_we;
            lat_wdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          hit <= lk_hit;
          if (lat_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= lat_addr;
            mem_wdata <= lat_wdata;
          end else if (lk_hit) begin
            outData   <= data_q[lat_idx][lk_way];
            cpu_ready <= 1'b1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= lat_addr;
          end
        end
        FILL: begin
          if (fill_done) begin
            valid_q[lat_idx][victim] <= 1'b1;
            outData   <= mem_rdata;
            cpu_ready <= 1'b1;
            mem_req   <= 1'b0;
          end
        end
        WRITE: begin
          if (write_done) begin
            cpu_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == LOOKUP) && lat_we && lk_hit)
      data_q[lat_idx][lk_way] <= lat_wdata;
    if (fill_done) begin
      tag_q[lat_idx][victim]  <= lat_tag;
      data_q[lat_idx][victim] <= mem_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (lk_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
